// File: rtl/err_eval_pkg.sv
// Shared types and width helpers for the approximate-arithmetic error evaluator.
//   state_e : sweep sequencer states
//   cnt_w() : width of the sweep counter and of the error counter (IN_W+1)
//   sum_w() : width of the absolute-error accumulator (OUT_W+IN_W)
package err_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One extra bit so the counter can represent N = 2^IN_W without wrapping.
  function automatic int cnt_w(input int in_w);
    return in_w + 1;
  endfunction

  // N points of at most 2^OUT_W-1 each fit in OUT_W+IN_W bits.
  function automatic int sum_w(input int in_w, input int out_w);
    return out_w + in_w;
  endfunction

endpackage

// File: rtl/err_eval_sweep_ctrl_if.sv
// Bus between the sweep controller and its harness (host control plus the
// approximate/exact datapaths).
//   master : harness side - drives start/abort and the two unit results
//   slave  : controller side - drives stimulus, status and error metrics
interface err_eval_sweep_ctrl_if
  import err_eval_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 14
);
  localparam int CNT_W = cnt_w(IN_W);
  localparam int SUM_W = sum_w(IN_W, OUT_W);

  logic             start;
  logic             abort;
  logic             stim_valid;
  logic [IN_W-1:0]  stim_data;
  logic [OUT_W-1:0] approx_res;
  logic [OUT_W-1:0] exact_res;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_cnt;
  logic [OUT_W-1:0] max_err;
  logic [SUM_W-1:0] sum_err;

  modport master (
    output start, abort, approx_res, exact_res,
    input  stim_valid, stim_data, busy, done, err_cnt, max_err, sum_err
  );

  modport slave (
    input  start, abort, approx_res, exact_res,
    output stim_valid, stim_data, busy, done, err_cnt, max_err, sum_err
  );

endinterface

// File: rtl/err_eval_accum.sv
// Two-stage error accumulator.
//   Stage 1 registers |approx-exact| and the not-equal flag for a valid slot.
//   Stage 2 folds that slot into err_cnt, max_err and sum_err.
// Ports:
//   clk, rst          clock, async active-high reset
//   valid_i           current approx_i/exact_i belong to a live sweep point
//   approx_i, exact_i results of the approximate and golden units
//   clear_i           zero all metrics and the stage-1 slot (new sweep)
//   flush_i           drop the in-flight slot without accumulating it (abort)
//   err_cnt_o, max_err_o, sum_err_o  running metrics
module err_eval_accum
  import err_eval_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 14
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_i,
  input  logic [OUT_W-1:0]                 approx_i,
  input  logic [OUT_W-1:0]                 exact_i,
  input  logic                             clear_i,
  input  logic                             flush_i,
  output logic [cnt_w(IN_W)-1:0]           err_cnt_o,
  output logic [OUT_W-1:0]                 max_err_o,
  output logic [sum_w(IN_W, OUT_W)-1:0]    sum_err_o
);
  localparam int CNT_W = cnt_w(IN_W);
  localparam int SUM_W = sum_w(IN_W, OUT_W);

  // One guard bit keeps the difference of two unsigned OUT_W values exact;
  // its magnitude always fits back into OUT_W bits.
  logic signed [OUT_W:0] diff;
  logic [OUT_W-1:0]      absdiff;

  assign diff    = $signed({1'b0, approx_i}) - $signed({1'b0, exact_i});
  assign absdiff = diff[OUT_W] ? OUT_W'(-diff) : OUT_W'(diff);

  logic             s1_vld_q;
  logic             s1_ne_q;
  logic [OUT_W-1:0] s1_abs_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [OUT_W-1:0] max_err_q;
  logic [SUM_W-1:0] sum_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_ne_q  <= 1'b0;
      s1_abs_q <= '0;
    end else begin
      s1_vld_q <= valid_i && !clear_i && !flush_i;
      s1_ne_q  <= (approx_i != exact_i);
      s1_abs_q <= absdiff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      max_err_q <= '0;
      sum_err_q <= '0;
    end else if (clear_i) begin
      err_cnt_q <= '0;
      max_err_q <= '0;
      sum_err_q <= '0;
    end else if (s1_vld_q && !flush_i) begin
      err_cnt_q <= err_cnt_q + CNT_W'(s1_ne_q);
      if (s1_abs_q > max_err_q) max_err_q <= s1_abs_q;
      sum_err_q <= sum_err_q + SUM_W'(s1_abs_q);
    end
  end

  assign err_cnt_o = err_cnt_q;
  assign max_err_o = max_err_q;
  assign sum_err_o = sum_err_q;

endmodule

// File: rtl/err_eval_sweep_ctrl.sv
// Exhaustive sweep sequencer for approximate-unit error evaluation.
// Drives every operand 0..2^IN_W-1 to the external approximate and exact
// units, tags their results through a DUT_LAT-deep valid delay line and
// feeds them to err_eval_accum for on-the-fly error metrics.
// Ports:
//   clk, rst   clock, async active-high reset
//   bus        slave side of err_eval_sweep_ctrl_if (start/abort, stimulus,
//              unit results, busy/done, err_cnt/max_err/sum_err)
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; metrics hold their last values
// ST_RUN   | issuing one sweep point per cycle (stim_valid=1)
// ST_DRAIN | all points issued; waiting for the pipeline to empty
// ST_DONE  | one-cycle done pulse, then back to ST_IDLE
module err_eval_sweep_ctrl
  import err_eval_pkg::*;
#(
  parameter int IN_W    = 12,
  parameter int OUT_W   = 14,
  parameter int DUT_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  err_eval_sweep_ctrl_if.slave  bus
);
  localparam int CNT_W = cnt_w(IN_W);
  localparam int N     = 1 << IN_W;
  localparam logic [CNT_W-1:0] LAST_PT = CNT_W'(N - 1);
  // Drain covers DUT_LAT result latency plus the two accumulator stages.
  localparam int DRN_W = $clog2(DUT_LAT + 2);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DUT_LAT + 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DRN_W-1:0] drn_q;
  logic             stim_valid_q;
  logic             busy_q;
  logic             done_q;

  logic start_acc;
  logic abort_acc;
  logic res_vld;

  assign start_acc = (state_q == ST_IDLE) && bus.start;
  assign abort_acc = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      drn_q        <= '0;
      stim_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            cnt_q        <= '0;
            stim_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_acc) begin
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_PT) begin
              stim_valid_q <= 1'b0;
              drn_q        <= DRN_LOAD;
              state_q      <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (abort_acc) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (drn_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            drn_q <= drn_q - DRN_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Valid tag travels alongside the external units' latency so the
  // accumulator only ever sees results belonging to a live point.
  generate
    if (DUT_LAT == 0) begin : g_no_lat
      assign res_vld = stim_valid_q;
    end else begin : g_lat
      logic [DUT_LAT-1:0] vld_sr_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_sr_q <= '0;
        end else if (abort_acc) begin
          vld_sr_q <= '0;
        end else begin
          vld_sr_q[0] <= stim_valid_q;
          for (int i = 1; i < DUT_LAT; i++) vld_sr_q[i] <= vld_sr_q[i-1];
        end
      end
      assign res_vld = vld_sr_q[DUT_LAT-1];
    end
  endgenerate

  err_eval_accum #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (res_vld),
    .approx_i  (bus.approx_res),
    .exact_i   (bus.exact_res),
    .clear_i   (start_acc),
    .flush_i   (abort_acc),
    .err_cnt_o (bus.err_cnt),
    .max_err_o (bus.max_err),
    .sum_err_o (bus.sum_err)
  );

  assign bus.stim_valid = stim_valid_q;
  assign bus.stim_data  = cnt_q[IN_W-1:0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_err_eval_sweep_ctrl.sv
module tb_err_eval_sweep_ctrl;
  localparam int IN_W  = 12;
  localparam int OUT_W = 14;
  localparam int N     = 1 << IN_W;
  localparam int LAT_B = 3;

  localparam int S_VLD = 0, S_DAT = 1, S_BSY = 2, S_DON = 3,
                 S_CNT = 4, S_MAX = 5, S_SUM = 6;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  int   mode_a = 0;
  int   mode_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  err_eval_sweep_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifa ();
  err_eval_sweep_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifb ();

  err_eval_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .DUT_LAT(0)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  err_eval_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .DUT_LAT(LAT_B)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );

  // Reference units: exact is a scaled square, approx depends on the test mode.
  function automatic logic [OUT_W-1:0] exact_f(input int mode, input logic [IN_W-1:0] x);
    int xi;
    xi = int'(x);
    if (mode == 3) return 14'd16383;
    return OUT_W'((xi * xi) >> 10);
  endfunction

  function automatic logic [OUT_W-1:0] approx_f(input int mode, input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] e;
    e = exact_f(mode, x);
    case (mode)
      1: return e ^ 14'd1;
      2: begin
        if (x == 12'd100)  return e + 14'd5;
        if (x == 12'd4095) return e - 14'd7;
        return e;
      end
      3: return 14'd0;
      default: return e;
    endcase
  endfunction

  always_comb begin
    ifa.exact_res  = exact_f(mode_a, ifa.stim_data);
    ifa.approx_res = approx_f(mode_a, ifa.stim_data);
  end

  logic [IN_W-1:0] d1, d2, d3;
  always @(posedge clk) begin
    d1 <= ifb.stim_data;
    d2 <= d1;
    d3 <= d2;
  end
  always_comb begin
    ifb.exact_res  = exact_f(mode_b, d3);
    ifb.approx_res = approx_f(mode_b, d3);
  end

  typedef struct {
    longint cnt;
    longint mx;
    longint sum;
  } exp_t;
  exp_t sbq[$];

  function automatic exp_t model(input int mode);
    exp_t r;
    int a, e, d;
    r.cnt = 0; r.mx = 0; r.sum = 0;
    for (int x = 0; x < N; x++) begin
      a = int'(approx_f(mode, IN_W'(x)));
      e = int'(exact_f(mode, IN_W'(x)));
      d = (a >= e) ? a - e : e - a;
      if (a != e) r.cnt++;
      if (d > r.mx) r.mx = d;
      r.sum += d;
    end
    return r;
  endfunction

  function automatic logic [63:0] sig(input int sel, input int which);
    if (sel == 0) begin
      case (which)
        S_VLD: return 64'(ifa.stim_valid);
        S_DAT: return 64'(ifa.stim_data);
        S_BSY: return 64'(ifa.busy);
        S_DON: return 64'(ifa.done);
        S_CNT: return 64'(ifa.err_cnt);
        S_MAX: return 64'(ifa.max_err);
        default: return 64'(ifa.sum_err);
      endcase
    end else begin
      case (which)
        S_VLD: return 64'(ifb.stim_valid);
        S_DAT: return 64'(ifb.stim_data);
        S_BSY: return 64'(ifb.busy);
        S_DON: return 64'(ifb.done);
        S_CNT: return 64'(ifb.err_cnt);
        S_MAX: return 64'(ifb.max_err);
        default: return 64'(ifb.sum_err);
      endcase
    end
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) ifa.start = v;
    else          ifb.start = v;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full sweep on instance sel; cycle 0 is the cycle in which start is sampled.
  task automatic run_sweep(input int sel, input int mode, input int lat,
                           input bit poke_run, input bit poke_done, input string tag);
    exp_t e;
    int c0, rel, done_at, first_busy, last_busy, nexp, seq_bad;
    if (sel == 0) mode_a = mode;
    else          mode_b = mode;
    sbq.push_back(model(mode));
    @(negedge clk);
    set_start(sel, 1'b1);
    c0 = cyc;
    @(negedge clk);
    set_start(sel, 1'b0);
    check({tag, "_cleared_cnt"}, sig(sel, S_CNT), 0);
    check({tag, "_cleared_sum"}, sig(sel, S_SUM), 0);
    done_at = -1; first_busy = -1; last_busy = -1; nexp = 0; seq_bad = 0;
    for (int k = 0; k < N + lat + 20 && done_at < 0; k++) begin
      rel = cyc - c0;
      if (sig(sel, S_BSY) == 1) begin
        if (first_busy < 0) first_busy = rel;
        last_busy = rel;
      end
      if (sig(sel, S_VLD) == 1) begin
        if (sig(sel, S_DAT) != 64'(nexp)) seq_bad++;
        nexp++;
      end
      if (poke_run && rel == 2000) set_start(sel, 1'b1);
      if (poke_run && rel == 2001) set_start(sel, 1'b0);
      if (sig(sel, S_DON) == 1) done_at = rel;
      else @(negedge clk);
    end
    e = sbq.pop_front();
    check({tag, "_done_cycle"}, 64'(done_at), 64'(N + lat + 3));
    check({tag, "_busy_first"}, 64'(first_busy), 1);
    check({tag, "_busy_last"},  64'(last_busy), 64'(N + lat + 2));
    check({tag, "_stim_count"}, 64'(nexp), 64'(N));
    check({tag, "_stim_order_errs"}, 64'(seq_bad), 0);
    check({tag, "_err_cnt"}, sig(sel, S_CNT), 64'(e.cnt));
    check({tag, "_max_err"}, sig(sel, S_MAX), 64'(e.mx));
    check({tag, "_sum_err"}, sig(sel, S_SUM), 64'(e.sum));
    if (poke_done) set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    check({tag, "_done_one_cycle"}, sig(sel, S_DON), 0);
    check({tag, "_idle_busy"}, sig(sel, S_BSY), 0);
    @(negedge clk);
    check({tag, "_stay_idle_busy"}, sig(sel, S_BSY), 0);
    check({tag, "_stay_idle_vld"}, sig(sel, S_VLD), 0);
    check({tag, "_hold_err_cnt"}, sig(sel, S_CNT), 64'(e.cnt));
  endtask

  initial begin
    int k, dones;
    logic [63:0] partial;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vld",  sig(0, S_VLD), 0);
    check("rst_dat",  sig(0, S_DAT), 0);
    check("rst_busy", sig(0, S_BSY), 0);
    check("rst_done", sig(0, S_DON), 0);
    check("rst_cnt",  sig(0, S_CNT), 0);
    check("rst_max",  sig(0, S_MAX), 0);
    check("rst_sum",  sig(0, S_SUM), 0);
    check("rst_b_busy", sig(1, S_BSY), 0);
    rst = 1'b0;
    @(negedge clk);

    run_sweep(0, 0, 0, 1'b0, 1'b0, "equal_lat0");
    run_sweep(0, 1, 0, 1'b0, 1'b0, "xor1_lat0");
    run_sweep(1, 1, LAT_B, 1'b0, 1'b0, "xor1_lat3");
    run_sweep(0, 2, 0, 1'b0, 1'b0, "inject");
    run_sweep(0, 3, 0, 1'b0, 1'b0, "full_scale");

    // Abort while stim_data = 1000 is being issued.
    mode_a = 1;
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    k = 0;
    while (!(ifa.stim_valid && ifa.stim_data == 12'd1000) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_1000", 64'(ifa.stim_data), 1000);
    ifa.abort = 1'b1;
    @(negedge clk);
    ifa.abort = 1'b0;
    check("abort_vld",  sig(0, S_VLD), 0);
    check("abort_busy", sig(0, S_BSY), 0);
    partial = sig(0, S_CNT);
    check("abort_partial_range", 64'((partial >= 998) && (partial <= 1001)), 1);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (ifa.done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dones), 0);
    check("abort_hold_cnt", sig(0, S_CNT), partial);
    check("abort_still_idle", sig(0, S_VLD), 0);

    // Restart after abort, with start poked during RUN and in the DONE cycle.
    run_sweep(0, 1, 0, 1'b1, 1'b1, "restart");

    // Reset in the middle of RUN.
    mode_a = 1;
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    repeat (500) @(negedge clk);
    check("pre_rst_busy", sig(0, S_BSY), 1);
    rst = 1'b1;
    #1;
    check("midrst_vld",  sig(0, S_VLD), 0);
    check("midrst_dat",  sig(0, S_DAT), 0);
    check("midrst_busy", sig(0, S_BSY), 0);
    check("midrst_done", sig(0, S_DON), 0);
    check("midrst_cnt",  sig(0, S_CNT), 0);
    check("midrst_max",  sig(0, S_MAX), 0);
    check("midrst_sum",  sig(0, S_SUM), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", sig(0, S_BSY), 0);
    run_sweep(0, 2, 0, 1'b0, 1'b0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
